// File: rtl/arb_mux2.sv
// Two-input packet-aware arbiter/mux: a packet, once started, keeps its input
// until its last word; new packets alternate round-robin. Output is registered.
module arb_mux2 #(
  parameter int WIDTH = 16
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic [WIDTH-1:0] In0_DI,
  input  logic             In0Valid_SI,
  input  logic             In0Last_SI,
  output logic             In0Ready_SO,
  input  logic [WIDTH-1:0] In1_DI,
  input  logic             In1Valid_SI,
  input  logic             In1Last_SI,
  output logic             In1Ready_SO,
  output logic [WIDTH-1:0] Out_DO,
  output logic             OutValid_SO,
  output logic             OutLast_SO,
  input  logic             OutReady_SI,
  output logic             Sel_SO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic             r_prio;
  logic             w_prioNext;

  logic             w_acc;
  logic             w_grantValid;
  logic             w_grantSel;
  logic             w_load;
  logic             w_selLast;
  logic [WIDTH-1:0] w_selData;

  logic [WIDTH-1:0] r_out;
  logic             r_outValid;
  logic             r_outLast;
  logic             r_sel;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_prio  <= w_prioNext;
    end
  end

  // Priority only moves when a new packet starts, so a locked packet never disturbs it.
  always_comb begin
    w_stateNext = r_state;
    w_prioNext  = r_prio;
    if (w_load) begin
      unique case (r_state)
        IDLE: begin
          w_prioNext = ~w_grantSel;
          if (!w_selLast) begin
            w_stateNext = w_grantSel ? LOCK1 : LOCK0;
          end
        end
        LOCK0, LOCK1: begin
          if (w_selLast) begin
            w_stateNext = IDLE;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    w_grantValid = 1'b0;
    w_grantSel   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (In0Valid_SI && In1Valid_SI) begin
          w_grantValid = 1'b1;
          w_grantSel   = r_prio;
        end else if (In0Valid_SI) begin
          w_grantValid = 1'b1;
          w_grantSel   = 1'b0;
        end else if (In1Valid_SI) begin
          w_grantValid = 1'b1;
          w_grantSel   = 1'b1;
        end
      end
      LOCK0: begin
        w_grantValid = In0Valid_SI;
        w_grantSel   = 1'b0;
      end
      LOCK1: begin
        w_grantValid = In1Valid_SI;
        w_grantSel   = 1'b1;
      end
      default: begin
        w_grantValid = 1'b0;
        w_grantSel   = 1'b0;
      end
    endcase
  end

  assign w_acc       = ~r_outValid | OutReady_SI;
  assign w_load      = w_acc & w_grantValid & ~Rst_RI;
  assign In0Ready_SO = w_load & ~w_grantSel;
  assign In1Ready_SO = w_load & w_grantSel;

  assign w_selData = w_grantSel ? In1_DI : In0_DI;
  assign w_selLast = w_grantSel ? In1Last_SI : In0Last_SI;

  // Output stage: load replaces the held word in the same cycle it drains.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_out      <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_sel      <= 1'b0;
    end else if (w_load) begin
      r_out      <= w_selData;
      r_outValid <= 1'b1;
      r_outLast  <= w_selLast;
      r_sel      <= w_grantSel;
    end else if (w_acc) begin
      r_outValid <= 1'b0;
    end
  end

  assign Out_DO      = r_out;
  assign OutValid_SO = r_outValid;
  assign OutLast_SO  = r_outLast;
  assign Sel_SO      = r_sel;

  a_oneReady : assert property (@(posedge Clk_CI) !(In0Ready_SO && In1Ready_SO));
  a_noReadyInReset : assert property (@(posedge Clk_CI) Rst_RI |-> !(In0Ready_SO || In1Ready_SO));
  a_holdOnStall : assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    (OutValid_SO && !OutReady_SI) |=> (OutValid_SO && $stable(Out_DO) && $stable(OutLast_SO) && $stable(Sel_SO)));

endmodule

// File: tb/tb_arb_mux2.sv
// Bench for arb_mux2: directed scenarios plus random traffic, all checked
// against a packet-level arbitration model kept in this file.
module tb_arb_mux2;

  localparam int WIDTH = 16;

  logic             Clk_CI = 1'b0;
  logic             Rst_RI;
  logic [WIDTH-1:0] In0_DI, In1_DI;
  logic             In0Valid_SI, In0Last_SI, In0Ready_SO;
  logic             In1Valid_SI, In1Last_SI, In1Ready_SO;
  logic [WIDTH-1:0] Out_DO;
  logic             OutValid_SO, OutLast_SO, OutReady_SI, Sel_SO;

  always #5 Clk_CI = ~Clk_CI;

  arb_mux2 #(.WIDTH(WIDTH)) dut (
    .Clk_CI(Clk_CI), .Rst_RI(Rst_RI),
    .In0_DI(In0_DI), .In0Valid_SI(In0Valid_SI), .In0Last_SI(In0Last_SI), .In0Ready_SO(In0Ready_SO),
    .In1_DI(In1_DI), .In1Valid_SI(In1Valid_SI), .In1Last_SI(In1Last_SI), .In1Ready_SO(In1Ready_SO),
    .Out_DO(Out_DO), .OutValid_SO(OutValid_SO), .OutLast_SO(OutLast_SO),
    .OutReady_SI(OutReady_SI), .Sel_SO(Sel_SO)
  );

  int checkCount = 0;
  int errorCount = 0;

  // Reference: which input owns an open packet (-1 none), whose turn it is, and the output word.
  int               mLock = -1;
  int               mPrio = 0;
  bit               mOutValid = 0;
  bit               mOutLast = 0;
  int               mSel = 0;
  logic [WIDTH-1:0] mOut = '0;

  bit   acc0, acc1;
  logic r0Seen, r1Seen;
  int   cnt0, cnt1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int modelGrant();
    if (mLock >= 0) begin
      if (mLock == 0) return In0Valid_SI ? 0 : -1;
      return In1Valid_SI ? 1 : -1;
    end
    if (In0Valid_SI && In1Valid_SI) return mPrio;
    if (In0Valid_SI) return 0;
    if (In1Valid_SI) return 1;
    return -1;
  endfunction

  task automatic stepCycle();
    int g;
    bit space;
    #1;
    space = !mOutValid || OutReady_SI;
    g = modelGrant();
    acc0 = !Rst_RI && space && (g == 0);
    acc1 = !Rst_RI && space && (g == 1);
    r0Seen = In0Ready_SO;
    r1Seen = In1Ready_SO;
    checkOutput("in0_ready", 32'(In0Ready_SO), 32'(acc0));
    checkOutput("in1_ready", 32'(In1Ready_SO), 32'(acc1));
    @(posedge Clk_CI);
    #1;
    if (Rst_RI) begin
      mLock = -1; mPrio = 0; mOutValid = 0; mOutLast = 0; mSel = 0; mOut = '0;
    end else if (space) begin
      if (g >= 0) begin
        mOut      = (g == 1) ? In1_DI : In0_DI;
        mOutLast  = (g == 1) ? In1Last_SI : In0Last_SI;
        mSel      = g;
        mOutValid = 1;
        if (mLock < 0) begin
          mPrio = 1 - g;
          if (!mOutLast) mLock = g;
        end else if (mOutLast) begin
          mLock = -1;
        end
      end else begin
        mOutValid = 0;
      end
    end
    checkOutput("out_valid", 32'(OutValid_SO), 32'(mOutValid));
    checkOutput("out_last", 32'(OutLast_SO), 32'(mOutLast));
    checkOutput("out_sel", 32'(Sel_SO), 32'(mSel));
    checkOutput("out_data", 32'(Out_DO), 32'(mOut));
  endtask

  task automatic doReset();
    Rst_RI = 1'b1;
    In0Valid_SI = 1'b0;
    In1Valid_SI = 1'b0;
    stepCycle();
    stepCycle();
    Rst_RI = 1'b0;
  endtask

  // Random sources hold a word until it is taken, like a real valid/ready producer.
  task automatic applyStimulus();
    Rst_RI      = ($urandom_range(0, 59) == 0);
    OutReady_SI = ($urandom_range(0, 3) != 0);
    if (!In0Valid_SI || acc0) begin
      In0Valid_SI = ($urandom_range(0, 3) != 0);
      In0_DI      = 16'hA000 | 16'(cnt0 & 'hfff);
      In0Last_SI  = ($urandom_range(0, 2) == 0);
      cnt0++;
    end
    if (!In1Valid_SI || acc1) begin
      In1Valid_SI = ($urandom_range(0, 3) != 0);
      In1_DI      = 16'hB000 | 16'(cnt1 & 'hfff);
      In1Last_SI  = ($urandom_range(0, 2) == 0);
      cnt1++;
    end
  endtask

  initial begin
    logic [15:0] contendSeq[4];
    logic [15:0] lockSeq[4];
    contendSeq = '{16'h000A, 16'h000B, 16'h000A, 16'h000B};
    lockSeq    = '{16'h0100, 16'h0101, 16'h0102, 16'h000B};

    In0_DI = '0; In1_DI = '0; In0Last_SI = 0; In1Last_SI = 0; OutReady_SI = 1;
    doReset();
    checkOutput("rst_valid", 32'(OutValid_SO), 32'h0);
    checkOutput("rst_data", 32'(Out_DO), 32'h0);

    // Single word
    In0Valid_SI = 1; In0_DI = 16'h1234; In0Last_SI = 1; OutReady_SI = 1;
    stepCycle();
    checkOutput("single_data", 32'(Out_DO), 32'h1234);
    checkOutput("single_valid", 32'(OutValid_SO), 32'h1);
    checkOutput("single_last", 32'(OutLast_SO), 32'h1);
    checkOutput("single_sel", 32'(Sel_SO), 32'h0);
    In0Valid_SI = 0;
    stepCycle();

    // Contention of single-word packets
    doReset();
    In0Valid_SI = 1; In0_DI = 16'h000A; In0Last_SI = 1;
    In1Valid_SI = 1; In1_DI = 16'h000B; In1Last_SI = 1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("contend_seq", 32'(Out_DO), 32'(contendSeq[i]));
    end

    // Packet lock
    doReset();
    In1Valid_SI = 1; In1_DI = 16'h000B; In1Last_SI = 1;
    In0Valid_SI = 1; In0_DI = 16'h0100; In0Last_SI = 0;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("lock_seq", 32'(Out_DO), 32'(lockSeq[i]));
      if (i < 3) checkOutput("lock_in1_ready", 32'(r1Seen), 32'h0);
      if (acc0) begin
        if (In0_DI == 16'h0102) begin
          In0Valid_SI = 0;
        end else begin
          In0_DI = In0_DI + 16'h1;
          In0Last_SI = (In0_DI == 16'h0102);
        end
      end
    end
    In1Valid_SI = 0;
    stepCycle();

    // Backpressure
    doReset();
    In0Valid_SI = 1; In0_DI = 16'h0200; In0Last_SI = 1;
    In1Valid_SI = 1; In1_DI = 16'h0300; In1Last_SI = 1;
    OutReady_SI = 1;
    stepCycle();
    if (acc0) In0_DI = In0_DI + 16'h1;
    OutReady_SI = 0;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("stall_data", 32'(Out_DO), 32'h0200);
      checkOutput("stall_readies", 32'({r0Seen, r1Seen}), 32'h0);
    end
    OutReady_SI = 1;
    stepCycle();
    checkOutput("release_first", 32'(Out_DO), 32'h0300);
    if (acc1) In1_DI = In1_DI + 16'h1;
    stepCycle();
    checkOutput("release_second", 32'(Out_DO), 32'h0201);
    In0Valid_SI = 0; In1Valid_SI = 0;
    stepCycle();

    // Reset in the middle of a locked packet
    doReset();
    In1Valid_SI = 1; In1_DI = 16'h0400; In1Last_SI = 0;
    stepCycle();
    checkOutput("midrst_first", 32'(Out_DO), 32'h0400);
    In1_DI = 16'h0401;
    Rst_RI = 1;
    stepCycle();
    checkOutput("midrst_ready", 32'(r1Seen), 32'h0);
    checkOutput("midrst_valid", 32'(OutValid_SO), 32'h0);
    Rst_RI = 0; In1Valid_SI = 0;
    In0Valid_SI = 1; In0_DI = 16'h0500; In0Last_SI = 1;
    stepCycle();
    checkOutput("midrst_grant0", 32'(r0Seen), 32'h1);
    checkOutput("midrst_data", 32'(Out_DO), 32'h0500);
    In0Valid_SI = 0;
    stepCycle();

    // Random traffic
    cnt0 = 0; cnt1 = 0; acc0 = 0; acc1 = 0;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
